// File: rtl/seq_det_pkg.sv
// Shared definitions for the "101" sequence detector and its word-level controller.
//   - Controller state encoding (IDLE/SHIFT/DRAIN/REPORT) as localparams and a typed enum.
//   - PATTERN: the serial pattern the detector recognises, for benches and reference models.
//   - max_hits(): upper bound on detections in a word of a given width.
package seq_det_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = IDLE,
        StShift  = SHIFT,
        StDrain  = DRAIN,
        StReport = REPORT
    } ctrl_state_e;

    localparam logic [2:0] PATTERN = 3'b101;

    // Non-overlapping word boundaries mean a 101 needs at least two fresh bits after the first.
    function automatic int unsigned max_hits(input int unsigned width);
        return (width - 1) / 2;
    endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Word handshake bundle between a producer/consumer and seq_det_ctrl.
//   in_valid/in_ready/in_data      : word offered to the controller
//   out_valid/out_ready            : result handshake
//   out_count/out_hits             : number of detections and per-bit hit map
// Modports: master = producer/consumer side, slave = controller side.
interface seq_det_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic [WIDTH-1:0] out_hits;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count,
        input  out_hits
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count,
        output out_hits
    );

endinterface

// File: rtl/seq_det.sv
// Serial "101" Moore sequence detector with overlap.
//   clock  : rising-edge clock
//   reset  : asynchronous, active-high reset
//   seq_in : serial input bit
//   det_o  : high for one cycle after the cycle in which a 101 completes
module seq_det
    import seq_det_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic seq_in,
    output logic det_o
);

    typedef enum logic [1:0] {
        StNone = 2'd0,
        StOne  = 2'd1,
        StOneZ = 2'd2,
        StHit  = 2'd3
    } det_state_e;

    det_state_e state_q, state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StNone;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StNone:  state_d = seq_in ? StOne : StNone;
            StOne:   state_d = seq_in ? StOne : StOneZ;
            StOneZ:  state_d = seq_in ? StHit : StNone;
            // Overlap: the trailing 1 can start the next match.
            StHit:   state_d = seq_in ? StOne : StOneZ;
            default: state_d = StNone;
        endcase
    end

    assign det_o = (state_q == StHit);

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-level controller for seq_det. Accepts a word, shifts it MSB-first into the
// detector, collects det_o pulses into a count and hit map, and returns the result.
//   clock, reset            : rising-edge clock, asynchronous active-low reset
//   bus (slave)             : input word and result handshakes
//   det_seq_in / det_reset  : drive seq_det.seq_in / seq_det.reset (active-high)
//   det_o_in                : seq_det.det_o
//   busy                    : controller is not idle
// All outputs decode from registers only.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic           clock,
    input  logic           reset,
    seq_det_ctrl_if.slave  bus,
    output logic           det_seq_in,
    output logic           det_reset,
    input  logic           det_o_in,
    output logic           busy
);

    localparam int unsigned POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);

    ctrl_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hits_q, hits_d;
    logic [POS_W-1:0] hit_idx;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (bus.in_valid) state_d = StShift;
            StShift:  if (pos_q == '0) state_d = StDrain;
            StDrain:  state_d = StReport;
            StReport: if (bus.out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StReport);
        det_reset     = (state_q == StIdle) || (state_q == StReport);
        det_seq_in    = (state_q == StShift) && shreg_q[WIDTH-1];
        busy          = (state_q != StIdle);
    end

    assign bus.out_count = count_q;
    assign bus.out_hits  = hits_q;

    // det_o_in reflects the bit driven one cycle earlier, i.e. position pos_q + 1.
    assign hit_idx = pos_q + 1'b1;

    always_comb begin
        shreg_d = shreg_q;
        pos_d   = pos_q;
        count_d = count_q;
        hits_d  = hits_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    shreg_d = bus.in_data;
                    pos_d   = POS_LAST;
                    count_d = '0;
                    hits_d  = '0;
                end
            end
            StShift: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                pos_d   = pos_q - 1'b1;
                // Nothing valid from the detector until it has seen one bit of this word.
                if ((pos_q != POS_LAST) && det_o_in) begin
                    count_d         = count_q + 1'b1;
                    hits_d[hit_idx] = 1'b1;
                end
            end
            StDrain: begin
                if (det_o_in) begin
                    count_d   = count_q + 1'b1;
                    hits_d[0] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            pos_q   <= '0;
            count_q <= '0;
            hits_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            pos_q   <= pos_d;
            count_q <= count_d;
            hits_q  <= hits_d;
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl paired with seq_det: table of words with hand-computed
// count/hit map, plus sequences for mid-word reset, result stall and word boundaries.
module tb_seq_det_ctrl;
    import seq_det_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic clock;
    logic reset;
    logic det_seq_in;
    logic det_reset;
    logic det_o;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    seq_det_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_det_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .det_seq_in (det_seq_in),
        .det_reset  (det_reset),
        .det_o_in   (det_o),
        .busy       (busy)
    );

    seq_det u_det (
        .clock  (clock),
        .reset  (det_reset),
        .seq_in (det_seq_in),
        .det_o  (det_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] hits;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer a word and return one step after the accepting edge (first SHIFT cycle).
    task automatic offer(input logic [WIDTH-1:0] data);
        int w;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = ~data;
        check("shift_busy", 32'(busy), 32'd1);
        check("shift_det_reset", 32'(det_reset), 32'd0);
        check("shift_first_bit", 32'(det_seq_in), 32'(data[WIDTH-1]));
    endtask

    // From the first SHIFT cycle, wait for the result and check it; stays in REPORT.
    task automatic finish_word(input string tag, input logic [CNT_W-1:0] cnt,
                               input logic [WIDTH-1:0] hits);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WIDTH + 2));
        check({tag, "_count"}, 32'(bus.out_count), 32'(cnt));
        check({tag, "_hits"}, 32'(bus.out_hits), 32'(hits));
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_det_reset"}, 32'(det_reset), 32'd1);
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("take_out_valid", 32'(bus.out_valid), 32'd0);
        check("take_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{data: 8'b0101_0110, cnt: 4'd2, hits: 8'b0001_0100};
        vecs[1] = '{data: 8'b1011_0101, cnt: 4'd3, hits: 8'b0010_0101};
        vecs[2] = '{data: 8'hFF,        cnt: 4'd0, hits: 8'h00};
        vecs[3] = '{data: 8'h00,        cnt: 4'd0, hits: 8'h00};
        vecs[4] = '{data: 8'b1010_1010, cnt: 4'd3, hits: 8'b0010_1010};
        vecs[5] = '{data: 8'b0101_0101, cnt: 4'd3, hits: 8'b0001_0101};
        vecs[6] = '{data: 8'b1110_0101, cnt: 4'd1, hits: 8'b0000_0001};
        vecs[7] = '{data: 8'b0000_0010, cnt: 4'd0, hits: 8'h00};
        vecs[8] = '{data: 8'b1000_0000, cnt: 4'd0, hits: 8'h00};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_det_reset", 32'(det_reset), 32'd1);
        check("rst_det_seq_in", 32'(det_seq_in), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        check("rst_out_hits", 32'(bus.out_hits), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Table-driven words
        for (int i = 0; i < 9; i++) begin
            offer(vecs[i].data);
            finish_word($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].hits);
            take();
        end

        // Reset low mid-SHIFT for 3 cycles
        offer(8'b1011_0101);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_det_reset", 32'(det_reset), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_hold_busy", 32'(busy), 32'd0);
        end
        check("midrst_count", 32'(bus.out_count), 32'd0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        offer(8'b1010_1010);
        finish_word("after_rst", 4'd3, 8'b0010_1010);
        take();

        // Result stalled 5 cycles with the next word already offered
        offer(8'b0101_0110);
        finish_word("stall_a", 4'd2, 8'b0001_0100);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'b1011_0101;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_count", 32'(bus.out_count), 32'd2);
            check("stall_hits", 32'(bus.out_hits), 32'h14);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("stall_idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("stall_idle_busy", 32'(busy), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("stall_b_accept", 32'(busy), 32'd1);
        check("stall_b_first_bit", 32'(det_seq_in), 32'd1);
        finish_word("stall_b", 4'd3, 8'b0010_0101);
        take();

        // Pattern straddling a word boundary; det_reset high for REPORT and IDLE
        offer(8'b0000_0010);
        finish_word("bnd_a", 4'd0, 8'h00);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'b1000_0000;
        tick();
        bus.out_ready = 1'b0;
        check("bnd_idle_det_reset", 32'(det_reset), 32'd1);
        check("bnd_idle_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bnd_shift_det_reset", 32'(det_reset), 32'd0);
        finish_word("bnd_b", 4'd0, 8'h00);
        take();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Word-level controller for the serial "101" Moore sequence detector `seq_det`. It accepts a parallel word through a valid/ready handshake and holds the detector in reset between words. It shifts the word MSB-first into the detector, one bit per clock, and collects `det_o` pulses into a hit count and a per-bit hit map. It returns the result through a second valid/ready handshake. It sits between a word-oriented producer/consumer and one `seq_det` instance in the parent.

## Interface
- `WIDTH`, 8: data word width, ≥3.
- `CNT_W`, 4: hit-count width; must satisfy 2^CNT_W > WIDTH/2.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: word offered.
- `in_ready` out 1: controller can accept a word.
- `in_data` in WIDTH: word; bit WIDTH-1 is shifted first.
- `det_seq_in` out 1: drives `seq_det.seq_in`.
- `det_reset` out 1: drives `seq_det.reset` (active-high).
- `det_o_in` in 1: from `seq_det.det_o`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `out_count` out CNT_W: number of 101 detections in the word.
- `out_hits` out WIDTH: bit i = 1 when a 101 completes on `in_data[i]`.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, SHIFT, DRAIN, REPORT.
- **IDLE**
  - `in_ready`=1 and `det_reset`=1.
  - On `in_valid`: load shift register with `in_data`, set pos=WIDTH-1, clear count and hits, go to SHIFT.
- **SHIFT**
  - `det_reset`=0 and `det_seq_in`=shreg[WIDTH-1].
  - Each cycle: shift left by 1 and decrement pos.
  - Sample `det_o_in`, except in the first SHIFT cycle. When sampled high: count+1 and hits[pos+1]=1.
  - `det_o_in` lags `det_seq_in` by one cycle, because `seq_det` is Moore.
  - After the cycle with pos=0, go to DRAIN.
- **DRAIN**
  - One cycle; `det_reset`=0 and `det_seq_in`=0.
  - If `det_o_in`=1: count+1 and hits[0]=1.
  - Go to REPORT.
- **REPORT**
  - `out_valid`=1 and `det_reset`=1.
  - `out_count` and `out_hits` are stable until the handshake.
  - On `out_ready`, go to IDLE.
- There is no cross-word overlap: detector history is discarded at each word boundary.
- Count is saturating-free by construction: at most floor((WIDTH-1)/2) hits.
- `in_data` changes after acceptance are ignored.
- `out_ready` outside REPORT is ignored.

## Timing
- Reset values: state IDLE, `in_ready`=1, `det_reset`=1, `det_seq_in`=0, `out_valid`=0, `out_count`=0, `out_hits`=0, `busy`=0.
- While `reset` is low, no handshake completes.
- All outputs decode from registered state and data. There is no combinational path from inputs to outputs.
- Word accepted at edge E:
  - SHIFT occupies cycles E+1..E+WIDTH.
  - DRAIN occupies cycle E+WIDTH+1.
  - `out_valid` rises in cycle E+WIDTH+2.
- Minimum period is WIDTH+3 cycles per word (REPORT→IDLE costs one cycle). For WIDTH=8 this is 11 cycles.
- `det_reset` is high for at least 2 consecutive cycles (REPORT + IDLE) between words. This satisfies both sync and async implementations of `seq_det`.
- Async reset mid-word:
  - Immediate return to IDLE; any partial result is discarded.
  - `det_reset`=1, so the detector is cleared as well.
- Simultaneous `in_valid` in REPORT: not accepted until IDLE.

## Structure
- Shared package `seq_det_pkg` holds:
  - State encoding localparams (IDLE=2'd0, SHIFT=2'd1, DRAIN=2'd2, REPORT=2'd3).
  - `PATTERN`=3'b101 for benches and reference models.
- No sub-module inside `seq_det_ctrl`.
- The existing `seq_det` is instantiated beside it in the parent, and the `det_*` ports connect 1:1.
- The bench instantiates both.

## Test plan
- `reset` low mid-SHIFT for 3 cycles → state IDLE immediately, `out_valid`=0, `det_reset`=1. The next word 8'b1010_1010 gives `out_count`=3 and `out_hits`=8'b0010_1010.
- WIDTH=8, `in_data`=8'b0101_0110 → `out_valid` at E+10, `out_count`=2, `out_hits`=8'b0001_0100.
- `in_data`=8'b1011_0101 (overlap) → `out_count`=3, `out_hits`=8'b0010_0101.
- `in_data`=8'hFF, then 8'h00 → `out_count`=0 and `out_hits`=0 for both.
- Word 8'b0000_0010 followed by 8'b1000_0000 (101 across boundary) → both report count 0, and `det_reset` is high ≥2 cycles between them.
- `out_ready` held low 5 cycles in REPORT with `in_valid`=1 → outputs stable, `in_ready`=0. The second word is accepted only in the IDLE cycle after the `out_ready` handshake.
